// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// word geometry and the byte-lane placement helper.
package imem_loader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int WORD_W         = 32;
   localparam int BYTES_PER_WORD = 4;

   // Bit offset of the lane that byte number idx of a word lands in.
   // Big-endian puts byte 0 at [31:24]; little-endian puts it at [7:0].
   function automatic logic [4:0] lane_lsb(input logic [1:0] idx, input logic big_endian);
      return big_endian ? {~idx, 3'b000} : {idx, 3'b000};
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
// slave = loader side, master = byte source / memory side.
interface imem_loader_if #(parameter int ADDR_W = 6);
   import imem_loader_pkg::*;

   logic              s_valid;
   logic [7:0]        s_data;
   logic              s_last;
   logic              s_ready;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [WORD_W-1:0] im_wdata;

   modport slave  (input  s_valid, s_data, s_last,
                   output s_ready, im_we, im_addr, im_wdata);
   modport master (output s_valid, s_data, s_last,
                   input  s_ready, im_we, im_addr, im_wdata);
endinterface

// File: rtl/imem_byte_packer.sv
// Collects bytes into a 32-bit word in the configured byte order.
// The word output already contains the byte being shifted in this cycle,
// so the loader can register a complete word on the final handshake.
module imem_byte_packer
   import imem_loader_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              clear,
   input  logic              shift_en,
   input  logic [7:0]        byte_in,
   output logic [1:0]        byte_idx,
   output logic [WORD_W-1:0] word
);

   logic [WORD_W-1:0] word_q;
   logic [4:0]        lsb;

   assign lsb = lane_lsb(byte_idx, BIG_ENDIAN);

   // Merge the incoming byte into its lane; untouched lanes stay zero.
   always_comb begin
      word = word_q;
      if (shift_en) word[lsb +: 8] = byte_in;
   end

   // Hold the partial word and the index of the next byte lane.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         byte_idx <= 2'd0;
         word_q   <= '0;
      end else if (clear) begin
         byte_idx <= 2'd0;
         word_q   <= '0;
      end else if (shift_en) begin
         byte_idx <= byte_idx + 2'd1;
         word_q   <= word;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Loads a program image from a byte stream into instruction memory and
// keeps the CPU held until the image is complete.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W     = 6,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          start,
   imem_loader_if.slave  bus,
   output logic          cpu_hold,
   output logic          done,
   output logic          err_overflow,
   output logic [ADDR_W:0] word_count
);

   state_t            state, next_state;
   logic              hs, word_end, start_ok, pk_clear, last_q;
   logic [1:0]        byte_idx;
   logic [WORD_W-1:0] packed_word;
   logic              im_we_q;
   logic [ADDR_W-1:0] im_addr_q;
   logic [WORD_W-1:0] im_wdata_q;

   // word_count doubles as the next word address; its top bit flags a full memory.
   assign hs       = bus.s_valid && bus.s_ready;
   assign word_end = hs && (byte_idx == 2'(BYTES_PER_WORD - 1) || bus.s_last);
   assign start_ok = start && (state == IDLE || state == DONE);
   assign pk_clear = start_ok || (state == WRITE);

   assign bus.s_ready  = (state == LOAD);
   assign cpu_hold     = (state != DONE);
   assign bus.im_we    = im_we_q;
   assign bus.im_addr  = im_addr_q;
   assign bus.im_wdata = im_wdata_q;

   imem_byte_packer #(.BIG_ENDIAN(BIG_ENDIAN)) u_packer (
      .clk      (clk),
      .resetn   (resetn),
      .clear    (pk_clear),
      .shift_en (hs),
      .byte_in  (bus.s_data),
      .byte_idx (byte_idx),
      .word     (packed_word)
   );

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= next_state;
   end

   // Next-state decode; WRITE always lasts exactly one cycle.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = LOAD;
         LOAD:    if (word_end) next_state = WRITE;
         WRITE:   next_state = last_q ? DONE : LOAD;
         DONE:    if (start) next_state = LOAD;
         default: next_state = IDLE;
      endcase
   end

   // Registered write port and status; the write is launched on the final
   // byte handshake so im_we is high during the WRITE cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         im_we_q      <= 1'b0;
         im_addr_q    <= '0;
         im_wdata_q   <= '0;
         done         <= 1'b0;
         err_overflow <= 1'b0;
         word_count   <= '0;
         last_q       <= 1'b0;
      end else begin
         im_we_q <= 1'b0;
         if (start_ok) begin
            im_addr_q    <= '0;
            done         <= 1'b0;
            err_overflow <= 1'b0;
            word_count   <= '0;
            last_q       <= 1'b0;
         end
         if (state == LOAD && word_end) begin
            last_q <= bus.s_last;
            if (!word_count[ADDR_W]) begin
               im_we_q    <= 1'b1;
               im_addr_q  <= word_count[ADDR_W-1:0];
               im_wdata_q <= packed_word;
               word_count <= word_count + (ADDR_W+1)'(1);
            end else begin
               err_overflow <= 1'b1;
            end
         end
         if (state == WRITE && last_q) done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: two instances with a 4-word memory,
// one big-endian and one little-endian, fed the same byte stream.
module tb_imem_loader;

   logic       clk = 1'b0;
   logic       resetn;
   logic       start;
   logic       cpu_hold_be, done_be, err_be;
   logic       cpu_hold_le, done_le, err_le;
   logic [2:0] wc_be, wc_le;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_we_cycle = 0;
   int acked = 0;

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t       q_be[$];
   exp_t       q_le[$];
   exp_t       e_be, e_le;
   logic [7:0] stim[$];

   imem_loader_if #(.ADDR_W(2)) if_be ();
   imem_loader_if #(.ADDR_W(2)) if_le ();

   imem_loader #(.ADDR_W(2), .BIG_ENDIAN(1'b1)) u_be (
      .clk(clk), .resetn(resetn), .start(start), .bus(if_be),
      .cpu_hold(cpu_hold_be), .done(done_be), .err_overflow(err_be), .word_count(wc_be));

   imem_loader #(.ADDR_W(2), .BIG_ENDIAN(1'b0)) u_le (
      .clk(clk), .resetn(resetn), .start(start), .bus(if_le),
      .cpu_hold(cpu_hold_le), .done(done_le), .err_overflow(err_le), .word_count(wc_le));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [1:0] a, input logic [31:0] wbe, input logic [31:0] wle);
      exp_t t;
      t.addr = a; t.data = wbe; q_be.push_back(t);
      t.data = wle; q_le.push_back(t);
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic l);
      if_be.s_valid = v; if_be.s_data = d; if_be.s_last = l;
      if_le.s_valid = v; if_le.s_data = d; if_le.s_last = l;
   endtask

   // Scoreboard monitor: every write must match the next expected word.
   always @(negedge clk) begin
      if (if_be.im_we) begin
         last_we_cycle <= cyc;
         check("we_ready_low", {31'd0, if_be.s_ready}, 32'd0);
         check("we_cpu_hold", {31'd0, cpu_hold_be}, 32'd1);
         if (q_be.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write_be addr=%0d data=%h required=no_write", if_be.im_addr, if_be.im_wdata);
         end else begin
            e_be = q_be.pop_front();
            check("wr_addr_be", {30'd0, if_be.im_addr}, {30'd0, e_be.addr});
            check("wr_data_be", if_be.im_wdata, e_be.data);
         end
      end
      if (if_le.im_we) begin
         if (q_le.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write_le addr=%0d data=%h required=no_write", if_le.im_addr, if_le.im_wdata);
         end else begin
            e_le = q_le.pop_front();
            check("wr_addr_le", {30'd0, if_le.im_addr}, {30'd0, e_le.addr});
            check("wr_data_le", if_le.im_wdata, e_le.data);
         end
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Offer every byte of stim; advance only on an observed handshake.
   task automatic send_stim(input bit gaps, input bit last_at_end);
      int  waitc;
      bit  acc;
      for (int i = 0; i < stim.size(); i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               drive(1'b0, 8'h00, 1'b0);
               @(posedge clk); #1;
            end
         end
         drive(1'b1, stim[i], last_at_end && (i == stim.size() - 1));
         waitc = 0;
         acc   = 1'b0;
         while (!acc && waitc < 40) begin
            @(negedge clk);
            acc = if_be.s_ready;
            @(posedge clk); #1;
            waitc++;
         end
         if (!acc) begin
            checks++; errors++;
            $display("FAIL handshake_timeout byte=%0d actual=no_ready required=ready", i);
            break;
         end
         acked++;
      end
      drive(1'b0, 8'h00, 1'b0);
   endtask

   task automatic wait_done(input bit chk_lat);
      int n;
      n = 0;
      @(negedge clk);
      while (!done_be && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("done_reached", {31'd0, done_be}, 32'd1);
      if (chk_lat) check("hold_fall_latency", cyc - last_we_cycle, 32'd1);
      @(posedge clk); #1;
      check("done_cpu_hold", {31'd0, cpu_hold_be}, 32'd0);
      check("done_ready", {31'd0, if_be.s_ready}, 32'd0);
      check("pending_be", q_be.size(), 32'd0);
      check("pending_le", q_le.size(), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_cpu_hold"}, {31'd0, cpu_hold_be}, 32'd1);
      check({tag, "_done"}, {31'd0, done_be}, 32'd0);
      check({tag, "_err"}, {31'd0, err_be}, 32'd0);
      check({tag, "_wc"}, {29'd0, wc_be}, 32'd0);
      check({tag, "_ready"}, {31'd0, if_be.s_ready}, 32'd0);
      check({tag, "_we"}, {31'd0, if_be.im_we}, 32'd0);
      check({tag, "_addr"}, {30'd0, if_be.im_addr}, 32'd0);
      check({tag, "_wdata"}, if_be.im_wdata, 32'd0);
      check({tag, "_cpu_hold_le"}, {31'd0, cpu_hold_le}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn = 1'b0;
      start  = 1'b0;
      drive(1'b0, 8'h00, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      @(negedge clk) resetn = 1'b1;
      @(posedge clk); #1;

      // s_valid in IDLE must not be taken
      drive(1'b1, 8'hFF, 1'b1);
      repeat (3) begin
         @(negedge clk);
         check("idle_ready", {31'd0, if_be.s_ready}, 32'd0);
      end
      @(posedge clk); #1;
      drive(1'b0, 8'h00, 1'b0);
      check("idle_wc", {29'd0, wc_be}, 32'd0);

      // Big-endian 8-byte image
      push_exp(2'd0, 32'h20010005, 32'h05000120);
      push_exp(2'd1, 32'h2002000A, 32'h0A000220);
      stim = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h0A};
      acked = 0;
      pulse_start();
      send_stim(1'b0, 1'b1);
      wait_done(1'b1);
      check("t1_wc", {29'd0, wc_be}, 32'd2);
      check("t1_err", {31'd0, err_be}, 32'd0);
      check("t1_acked", acked, 32'd8);

      // Partial word AA BB CC
      push_exp(2'd0, 32'hAABBCC00, 32'h00CCBBAA);
      stim = '{8'hAA, 8'hBB, 8'hCC};
      pulse_start();
      send_stim(1'b0, 1'b1);
      wait_done(1'b0);
      check("t2_wc", {29'd0, wc_be}, 32'd1);

      // Single-byte image
      push_exp(2'd0, 32'h7F000000, 32'h0000007F);
      stim = '{8'h7F};
      pulse_start();
      send_stim(1'b0, 1'b1);
      wait_done(1'b0);
      check("t3_wc", {29'd0, wc_be}, 32'd1);

      // Random gaps on s_valid
      push_exp(2'd0, 32'h01020304, 32'h04030201);
      push_exp(2'd1, 32'h05060708, 32'h08070605);
      push_exp(2'd2, 32'h090A0B0C, 32'h0C0B0A09);
      stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
      acked = 0;
      pulse_start();
      send_stim(1'b1, 1'b1);
      wait_done(1'b0);
      check("t4_wc", {29'd0, wc_be}, 32'd3);
      check("t4_acked", acked, 32'd12);

      // Overflow: 5 words into a 4-word memory
      push_exp(2'd0, 32'h30313233, 32'h33323130);
      push_exp(2'd1, 32'h34353637, 32'h37363534);
      push_exp(2'd2, 32'h38393A3B, 32'h3B3A3938);
      push_exp(2'd3, 32'h3C3D3E3F, 32'h3F3E3D3C);
      stim.delete();
      for (int i = 0; i < 20; i++) stim.push_back(8'(8'h30 + i));
      acked = 0;
      pulse_start();
      send_stim(1'b0, 1'b1);
      wait_done(1'b0);
      check("ovf_err", {31'd0, err_be}, 32'd1);
      check("ovf_err_le", {31'd0, err_le}, 32'd1);
      check("ovf_wc", {29'd0, wc_be}, 32'd4);
      check("ovf_acked", acked, 32'd20);

      // Reload from DONE, with a start pulse during LOAD ignored
      pulse_start();
      check("reload_cpu_hold", {31'd0, cpu_hold_be}, 32'd1);
      check("reload_done", {31'd0, done_be}, 32'd0);
      check("reload_wc", {29'd0, wc_be}, 32'd0);
      check("reload_err", {31'd0, err_be}, 32'd0);
      push_exp(2'd0, 32'hDEADBEEF, 32'hEFBEADDE);
      stim = '{8'hDE, 8'hAD};
      send_stim(1'b0, 1'b0);
      pulse_start();
      stim = '{8'hBE, 8'hEF};
      send_stim(1'b0, 1'b1);
      wait_done(1'b0);
      check("reload2_wc", {29'd0, wc_be}, 32'd1);

      // Reset in the middle of a load
      pulse_start();
      stim = '{8'h99, 8'h88};
      send_stim(1'b0, 1'b0);
      resetn = 1'b0;
      #2;
      check_reset_vals("midrst");
      repeat (2) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      @(posedge clk); #1;
      push_exp(2'd0, 32'h12345678, 32'h78563412);
      stim = '{8'h12, 8'h34, 8'h56, 8'h78};
      pulse_start();
      send_stim(1'b0, 1'b1);
      wait_done(1'b0);
      check("post_rst_wc", {29'd0, wc_be}, 32'd1);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side companion to the instruction memory that the pipeline's fetch stage reads.
- Accepts a byte stream over a valid/ready handshake and packs it into 32-bit instruction words, big-endian by default.
- Writes each word into instruction memory at consecutive word addresses, starting at word 0.
- Holds the CPU pipeline off (cpu_hold) until the program image is fully loaded.

Parameters:
- ADDR_W, 6, word-address width; memory depth is 2**ADDR_W words.
- BIG_ENDIAN, 1, 1 = first received byte goes to bits [31:24]; 0 = first received byte goes to bits [7:0].

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins a load; sampled only in IDLE or DONE.
- s_valid  input  1  byte-stream valid.
- s_data  input  8  byte-stream data.
- s_last  input  1  marks the final byte of the image; qualified by s_valid && s_ready.
- s_ready  output  1  loader can accept a byte.
- im_we  output  1  instruction-memory write enable, one-cycle pulse.
- im_addr  output  ADDR_W  word address of the write (fetch byte address = im_addr*4).
- im_wdata  output  32  instruction word to write.
- cpu_hold  output  1  1 = pipeline PC and stage registers held in reset/stall.
- done  output  1  load complete, level.
- err_overflow  output  1  sticky; image exceeded memory depth.
- word_count  output  ADDR_W+1  number of words written in the current or last load.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE; s_ready=0, im_we=0, im_addr=0, im_wdata=0, done=0, err_overflow=0, word_count=0, cpu_hold=1.
  - The byte counter and the partial word are cleared.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - cpu_hold=1, s_ready=0.
  - start=1 -> LOAD; clear the word address, byte counter, word_count and err_overflow.
- LOAD:
  - s_ready=1.
  - Each handshake (s_valid && s_ready) shifts s_data into the packer and increments the 2-bit byte counter.
  - Handshake on byte index 3 -> WRITE next cycle.
  - Handshake with s_last on byte index 0-2 -> WRITE next cycle. Unfilled byte lanes are zero: byte positions after the last byte received, in the configured endianness.
  - start is ignored in LOAD.
- WRITE (exactly one cycle):
  - s_ready=0.
  - If word address < 2**ADDR_W: im_we=1, im_wdata = packed word, im_addr = current word address. Then increment the word address and word_count.
  - Otherwise: im_we=0, err_overflow<=1, word discarded.
  - Next state: DONE if the final byte of this word carried s_last, else LOAD. The packer and byte counter are cleared.
- Latency and throughput:
  - The 4th-byte handshake in cycle N gives im_we in cycle N+1.
  - Peak throughput is 4 bytes per 5 cycles.
  - s_data and s_last are sampled only on a handshake; the loader never drops a byte it has acknowledged.
- Overflow:
  - When the address reaches the depth, bytes are still accepted and drained until s_last, so the source never deadlocks.
  - Overflowing words are never written.
  - im_addr does not wrap.
- DONE:
  - done=1, cpu_hold=0, s_ready=0.
  - im_addr, word_count and err_overflow hold their values.
  - start=1 -> LOAD with cpu_hold=1 asserted in the same cycle the state changes (registered); done drops; counters clear as in IDLE.
- cpu_hold=1 in every state except DONE.
- s_valid with s_ready=0 has no effect.
- resetn asserted mid-load aborts it: the partial word is discarded and no write occurs.
- Empty image: s_last on byte index 0 writes one word containing byte 0 only.
- im_we is never asserted outside WRITE.
- Outputs are registered except s_ready and cpu_hold, which decode the state directly.

Decomposition:
- Shared package imem_loader_pkg holds:
  - the state encoding (IDLE=2'd0, LOAD=2'd1, WRITE=2'd2, DONE=2'd3);
  - WORD_W=32 and BYTES_PER_WORD=4.
- One sub-module, imem_byte_packer:
  - inputs: clk, resetn, clear, shift_en, byte_in, BIG_ENDIAN;
  - outputs: 2-bit byte_idx and the 32-bit word with zero-fill of unused lanes.
  - The FSM stays in imem_loader.

Test Plan:
- Big-endian 8-byte load: bytes 20 01 00 05 | 20 02 00 0A, last on the 8th, then start. Expect im_we at addr 0 with 0x20010005 and at addr 1 with 0x2002000A. done=1, word_count=2, cpu_hold falls the cycle after the 2nd write, err_overflow=0.
- Partial word, BIG_ENDIAN=1: bytes AA BB CC with last on CC. Expect one write, addr 0, data 0xAABBCC00. With BIG_ENDIAN=0 the same stream writes 0x00CCBBAA.
- Backpressure and gaps:
  - s_valid toggled randomly: every acknowledged byte is written exactly once.
  - s_ready=0 during each WRITE cycle, and a byte held there is accepted next cycle.
- Overflow, ADDR_W=2: send 20 bytes (5 words) with last.
  - Expect 4 writes at addr 0-3 and no 5th write.
  - err_overflow=1, word_count=4, all 20 bytes acknowledged, done=1.
- Reset mid-load: pull resetn low after 2 bytes.
  - All outputs return to their reset values, cpu_hold=1, no im_we pulse.
  - A new start followed by a 4-byte image writes addr 0.
- Reload: start pulsed in DONE.
  - cpu_hold=1, done=0, word_count=0.
  - The new image overwrites from addr 0.
  - A start pulse in LOAD has no effect.
